// File: rtl/jt51_kon_gen.sv
// Key-on sequencer for the FM operator pipeline.
// Owns the slot counter, holds one host key-on bit per channel/operator slot,
// applies host writes as matching slots rotate past, injects CSM key-on bursts
// and flags key-on/key-off edges of the effective key-on to the envelope stage.
module jt51_kon_gen #(
  parameter int unsigned CH     = 8,
  parameter int unsigned OPS    = 4,
  parameter int unsigned CSM_CH = 7,
  parameter int unsigned SWAP12 = 1,
  localparam int unsigned CHW   = $clog2(CH),
  localparam int unsigned OPW   = $clog2(OPS),
  localparam int unsigned SLOTS = CH * OPS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic [OPS-1:0] keyon_op,
  input  logic [CHW-1:0] keyon_ch,
  input  logic           up_keyon,
  output logic           busy,
  input  logic           csm,
  input  logic           overflow_A,
  output logic [CHW-1:0] cur_ch,
  output logic [OPW-1:0] cur_op,
  output logic           zero,
  output logic           keyon,
  output logic           kon_pulse,
  output logic           koff_pulse
);

  localparam int unsigned SW   = $clog2(SLOTS);
  localparam int unsigned CNTW = $clog2(SLOTS + 1);

  // Slot position, kept both as a flat index and as op-major ch/op counters
  // so no divider is needed for non power-of-two channel counts.
  logic [SW-1:0]    s_q;
  logic [CHW-1:0]   ch_q;
  logic [OPW-1:0]   op_q;

  logic [SLOTS-1:0] kst_q;
  logic [SLOTS-1:0] pst_q;

  logic             busy_q;
  logic [CNTW-1:0]  rem_q;
  logic [OPS-1:0]   pend_op_q;
  logic [CHW-1:0]   pend_ch_q;
  logic [CNTW-1:0]  csm_cnt_q;

  logic             keyon_q;
  logic             kon_q;
  logic             koff_q;

  logic [OPW-1:0]   map_op;
  logic             wr_hit;
  logic             kst_cur;
  logic             csm_force;
  logic             eff;

  // Host operator bit order differs from slot order when operators 1 and 2 swap.
  always_comb begin
    map_op = op_q;
    if (SWAP12 != 0 && OPS == 4) begin
      if (op_q == OPW'(1)) begin
        map_op = OPW'(2);
      end else if (op_q == OPW'(2)) begin
        map_op = OPW'(1);
      end
    end
  end

  // Effective key-on of the presented slot: pending write wins over stored state,
  // and an active CSM burst forces the CSM channel on.
  always_comb begin
    wr_hit    = busy_q && (ch_q == pend_ch_q);
    kst_cur   = wr_hit ? pend_op_q[map_op] : kst_q[s_q];
    csm_force = (csm_cnt_q != '0) && (ch_q == CHW'(CSM_CH));
    eff       = kst_cur | csm_force;
  end

  // Slot rotation, key state storage, write/CSM sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      ch_q      <= '0;
      op_q      <= '0;
      kst_q     <= '0;
      pst_q     <= '0;
      busy_q    <= 1'b0;
      rem_q     <= '0;
      pend_op_q <= '0;
      pend_ch_q <= '0;
      csm_cnt_q <= '0;
      keyon_q   <= 1'b0;
      kon_q     <= 1'b0;
      koff_q    <= 1'b0;
    end else if (cen) begin
      if (s_q == SW'(SLOTS - 1)) begin
        s_q <= '0;
      end else begin
        s_q <= s_q + SW'(1);
      end
      if (ch_q == CHW'(CH - 1)) begin
        ch_q <= '0;
        if (op_q == OPW'(OPS - 1)) begin
          op_q <= '0;
        end else begin
          op_q <= op_q + OPW'(1);
        end
      end else begin
        ch_q <= ch_q + CHW'(1);
      end

      kst_q[s_q] <= kst_cur;
      pst_q[s_q] <= eff;
      keyon_q    <= eff;
      kon_q      <= eff & ~pst_q[s_q];
      koff_q     <= ~eff & pst_q[s_q];

      // A write covers exactly one full rotation; requests while busy are dropped.
      if (busy_q) begin
        rem_q <= rem_q - CNTW'(1);
        if (rem_q == CNTW'(1)) begin
          busy_q <= 1'b0;
        end
      end else if (up_keyon) begin
        busy_q    <= 1'b1;
        rem_q     <= CNTW'(SLOTS);
        pend_op_q <= keyon_op;
        pend_ch_q <= keyon_ch;
      end

      // Re-trigger reloads the burst; clearing csm does not cancel it.
      if (csm && overflow_A) begin
        csm_cnt_q <= CNTW'(SLOTS);
      end else if (csm_cnt_q != '0) begin
        csm_cnt_q <= csm_cnt_q - CNTW'(1);
      end
    end
  end

  assign cur_ch     = ch_q;
  assign cur_op     = op_q;
  assign zero       = (s_q == '0);
  assign busy       = busy_q;
  assign keyon      = keyon_q;
  assign kon_pulse  = kon_q;
  assign koff_pulse = koff_q;

endmodule
